// File: rtl/mult_thread_arbiter.sv
// Round-robin front end that shares one single-cycle multiplier between hardware threads and
// returns each tagged result to its owning thread through a 1-entry per-thread result buffer.
module mult_thread_arbiter #(
    parameter int unsigned  NumThreads  = 2,
    parameter int unsigned  Xlen        = 64,
    parameter int unsigned  TransIdBits = 3,
    parameter int unsigned  OpWidth     = 8,
    localparam int unsigned TW          = (NumThreads > 1) ? $clog2(NumThreads) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    // Per-thread issue side
    input  logic [NumThreads-1:0]                   req_valid_i,
    output logic [NumThreads-1:0]                   req_ready_o,
    input  logic [NumThreads-1:0][OpWidth-1:0]      req_op_i,
    input  logic [NumThreads-1:0][Xlen-1:0]         req_a_i,
    input  logic [NumThreads-1:0][Xlen-1:0]         req_b_i,
    input  logic [NumThreads-1:0][TransIdBits-1:0]  req_trans_id_i,
    input  logic [NumThreads-1:0]                   flush_i,
    // Multiplier issue port
    output logic                                    mult_valid_o,
    output logic [OpWidth-1:0]                      mult_op_o,
    output logic [Xlen-1:0]                         mult_a_o,
    output logic [Xlen-1:0]                         mult_b_o,
    output logic [TransIdBits-1:0]                  mult_trans_id_o,
    output logic [TW-1:0]                           mult_thread_id_o,
    // Multiplier result port
    input  logic                                    mult_valid_i,
    input  logic [Xlen-1:0]                         mult_result_i,
    input  logic [TransIdBits-1:0]                  mult_trans_id_i,
    input  logic [TW-1:0]                           mult_thread_id_i,
    // Per-thread result side
    output logic [NumThreads-1:0]                   res_valid_o,
    input  logic [NumThreads-1:0]                   res_ready_i,
    output logic [NumThreads-1:0][Xlen-1:0]         res_data_o,
    output logic [NumThreads-1:0][TransIdBits-1:0]  res_trans_id_o
);

    logic [NumThreads-1:0]                  busy_q, busy_d;
    logic [NumThreads-1:0]                  kill_q, kill_d;
    logic [NumThreads-1:0]                  buf_valid_q, buf_valid_d;
    logic [NumThreads-1:0][Xlen-1:0]        buf_data_q, buf_data_d;
    logic [NumThreads-1:0][TransIdBits-1:0] buf_tid_q, buf_tid_d;
    logic [TW-1:0]                          rr_ptr_q, rr_ptr_d;

    logic [NumThreads-1:0] handshake;
    logic [NumThreads-1:0] eligible;
    logic [NumThreads-1:0] ret_hit;
    logic [NumThreads-1:0] grant;
    logic [TW-1:0]         grant_idx;
    logic                  grant_any;

    // A thread whose buffered result drains this cycle may issue again in the same cycle.
    always_comb begin
        handshake = buf_valid_q & res_ready_i;
        eligible  = '0;
        if (!rst_i) begin
            eligible = req_valid_i & ~flush_i & (~busy_q | handshake);
        end
    end

    always_comb begin
        ret_hit = '0;
        for (int unsigned t = 0; t < NumThreads; t++) begin
            ret_hit[t] = mult_valid_i && !rst_i && busy_q[t] && (mult_thread_id_i == TW'(t));
        end
    end

    always_comb begin
        logic [TW-1:0] cand;
        cand      = '0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned i = 0; i < NumThreads; i++) begin
            cand = TW'((32'(rr_ptr_q) + i) % NumThreads);
            if (!grant_any && eligible[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready_o      = grant;
        mult_valid_o     = grant_any;
        mult_op_o        = req_op_i[grant_idx];
        mult_a_o         = req_a_i[grant_idx];
        mult_b_o         = req_b_i[grant_idx];
        mult_trans_id_o  = req_trans_id_i[grant_idx];
        mult_thread_id_o = grant_idx;
    end

    always_comb begin
        busy_d      = busy_q;
        kill_d      = kill_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        buf_tid_d   = buf_tid_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = TW'((32'(grant_idx) + 1) % NumThreads);
        end
        for (int unsigned t = 0; t < NumThreads; t++) begin
            if (handshake[t]) begin
                buf_valid_d[t] = 1'b0;
                busy_d[t]      = 1'b0;
            end
            if (ret_hit[t]) begin
                if (kill_q[t] || flush_i[t]) begin
                    busy_d[t] = 1'b0;
                    kill_d[t] = 1'b0;
                end else begin
                    buf_valid_d[t] = 1'b1;
                    buf_data_d[t]  = mult_result_i;
                    buf_tid_d[t]   = mult_trans_id_i;
                end
            end
            // An op still in the multiplier cannot be recalled, so mark it for discard on return.
            if (flush_i[t]) begin
                buf_valid_d[t] = 1'b0;
                if (busy_q[t] && !buf_valid_q[t] && !ret_hit[t]) begin
                    kill_d[t] = 1'b1;
                end else begin
                    busy_d[t] = 1'b0;
                end
            end
            if (grant[t]) begin
                busy_d[t] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q      <= '0;
            kill_q      <= '0;
            buf_valid_q <= '0;
            buf_data_q  <= '0;
            buf_tid_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            busy_q      <= busy_d;
            kill_q      <= kill_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            buf_tid_q   <= buf_tid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign res_valid_o    = buf_valid_q;
    assign res_data_o     = buf_data_q;
    assign res_trans_id_o = buf_tid_q;

`ifndef SYNTHESIS
    logic issued_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issued_q <= 1'b0;
        end else begin
            issued_q <= mult_valid_o;
        end
    end

    a_result_follows_issue : assert property (@(posedge clk_i) disable iff (rst_i)
        mult_valid_i |-> issued_q);
    a_grant_onehot : assert property (@(posedge clk_i) $onehot0(grant));
    a_no_busy_grant : assert property (@(posedge clk_i) disable iff (rst_i)
        (grant & busy_q & ~handshake) == '0);
`endif

endmodule

// File: tb/tb_mult_thread_arbiter.sv
// Randomized scoreboard bench for mult_thread_arbiter with a behavioural multiplier and a
// per-thread Idle/InFlight/Buffered reference model.
module tb_mult_thread_arbiter;

    localparam int N  = 2;
    localparam int XL = 64;
    localparam int TB = 3;
    localparam int OW = 8;
    localparam int TW = 1;

    localparam logic [7:0] OpMul    = 8'd0;
    localparam logic [7:0] OpMulh   = 8'd1;
    localparam logic [7:0] OpMulhu  = 8'd2;
    localparam logic [7:0] OpMulhsu = 8'd3;
    localparam logic [7:0] OpMulw   = 8'd4;
    localparam logic [7:0] OpClmul  = 8'd5;
    localparam logic [7:0] OpClmulh = 8'd6;
    localparam logic [7:0] OpClmulr = 8'd7;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N-1:0]            req_valid, req_ready, flush, res_valid, res_ready;
    logic [N-1:0][OW-1:0]    req_op;
    logic [N-1:0][XL-1:0]    req_a, req_b, res_data;
    logic [N-1:0][TB-1:0]    req_tid, res_tid;
    logic                    mult_valid;
    logic [OW-1:0]           mult_op;
    logic [XL-1:0]           mult_a, mult_b;
    logic [TB-1:0]           mult_tid;
    logic [TW-1:0]           mult_thr;
    logic                    mv_q = 1'b0;
    logic [XL-1:0]           mres_q = '0;
    logic [TB-1:0]           mtid_q = '0;
    logic [TW-1:0]           mthr_q = '0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum int {MIdle, MFlight, MBuf} mst_e;
    typedef struct packed {
        logic [XL-1:0] data;
        logic [TB-1:0] tid;
    } exp_t;

    mst_e  st [N];
    int    m_ptr;
    exp_t  expq [N][$];

    always #5 clk = ~clk;

    mult_thread_arbiter #(
        .NumThreads (N),
        .Xlen       (XL),
        .TransIdBits(TB),
        .OpWidth    (OW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_op_i        (req_op),
        .req_a_i         (req_a),
        .req_b_i         (req_b),
        .req_trans_id_i  (req_tid),
        .flush_i         (flush),
        .mult_valid_o    (mult_valid),
        .mult_op_o       (mult_op),
        .mult_a_o        (mult_a),
        .mult_b_o        (mult_b),
        .mult_trans_id_o (mult_tid),
        .mult_thread_id_o(mult_thr),
        .mult_valid_i    (mv_q),
        .mult_result_i   (mres_q),
        .mult_trans_id_i (mtid_q),
        .mult_thread_id_i(mthr_q),
        .res_valid_o     (res_valid),
        .res_ready_i     (res_ready),
        .res_data_o      (res_data),
        .res_trans_id_o  (res_tid)
    );

    function automatic logic [XL-1:0] ref_mult(input logic [7:0] op, input logic [XL-1:0] a,
                                               input logic [XL-1:0] b);
        logic [2*XL-1:0] p;
        logic [31:0]     w;
        p = '0;
        w = '0;
        case (op)
            OpMul:    begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
            OpMulh:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            OpMulhu:  begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
            OpMulhsu: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
            OpMulw:   begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
            OpClmul, OpClmulh, OpClmulr: begin
                for (int i = 0; i < XL; i++) begin
                    if (b[i]) p = p ^ ({64'b0, a} << i);
                end
                if (op == OpClmul) return p[63:0];
                if (op == OpClmulh) return p[127:64];
                return p[126:63];
            end
            default:  return '0;
        endcase
    endfunction

    function automatic void chk(input string name, input logic [63:0] got,
                                input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
        end
    endfunction

    // Multiplier stand-in: one cycle of latency, tag echoed back.
    always @(posedge clk) begin
        mv_q   <= mult_valid;
        mres_q <= ref_mult(mult_op, mult_a, mult_b);
        mtid_q <= mult_tid;
        mthr_q <= mult_thr;
    end

    // Monitor: pops the expected entry on every result handshake.
    exp_t mon_e;
    always @(negedge clk) begin
        for (int t = 0; t < N; t++) begin
            if (res_valid[t] && res_ready[t]) begin
                if (expq[t].size() == 0) begin
                    chk($sformatf("unexpected_result_t%0d", t), 64'(res_valid[t]), 64'd0);
                end else begin
                    mon_e = expq[t].pop_front();
                    chk($sformatf("res_data_t%0d", t), res_data[t], mon_e.data);
                    chk($sformatf("res_tid_t%0d", t), 64'(res_tid[t]), 64'(mon_e.tid));
                end
            end
        end
    end

    // Reference model: evaluates the cycle's inputs, predicts grant, then advances.
    logic [N-1:0] m_hs, m_elig, m_grant;
    int           g;
    exp_t         ne;
    always @(negedge clk) begin
        #1;
        m_hs    = '0;
        m_elig  = '0;
        m_grant = '0;
        g       = -1;
        if (!rst) begin
            for (int t = 0; t < N; t++) begin
                m_hs[t]   = (st[t] == MBuf) && res_ready[t];
                m_elig[t] = req_valid[t] && !flush[t] && (st[t] == MIdle || m_hs[t]);
            end
        end
        for (int k = 0; k < N; k++) begin
            for (int t = 0; t < N; t++) begin
                if (g < 0 && t == (m_ptr + k) % N && m_elig[t]) g = t;
            end
        end
        for (int t = 0; t < N; t++) if (t == g) m_grant[t] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(m_grant));
        chk("mult_valid", 64'(mult_valid), 64'(g >= 0));
        for (int t = 0; t < N; t++) begin
            if (t == g) begin
                chk("mult_op", 64'(mult_op), 64'(req_op[t]));
                chk("mult_a", mult_a, req_a[t]);
                chk("mult_b", mult_b, req_b[t]);
                chk("mult_tid", 64'(mult_tid), 64'(req_tid[t]));
                chk("mult_thread", 64'(mult_thr), 64'(t));
            end
            chk($sformatf("res_valid_t%0d", t), 64'(res_valid[t]), 64'(st[t] == MBuf));
            if (st[t] == MBuf && !m_hs[t] && expq[t].size() > 0) begin
                chk($sformatf("res_hold_t%0d", t), res_data[t], expq[t][0].data);
            end
        end
        if (rst) begin
            for (int t = 0; t < N; t++) begin
                st[t] = MIdle;
                expq[t].delete();
            end
            m_ptr = 0;
        end else begin
            for (int t = 0; t < N; t++) begin
                case (st[t])
                    MBuf: begin
                        if (flush[t] || m_hs[t]) begin
                            if (!m_hs[t] && expq[t].size() > 0) void'(expq[t].pop_front());
                            st[t] = MIdle;
                        end
                    end
                    MFlight: begin
                        if (flush[t]) begin
                            if (expq[t].size() > 0) void'(expq[t].pop_back());
                            st[t] = MIdle;
                        end else begin
                            st[t] = MBuf;
                        end
                    end
                    default: ;
                endcase
                if (t == g) begin
                    ne.data = ref_mult(req_op[t], req_a[t], req_b[t]);
                    ne.tid  = req_tid[t];
                    expq[t].push_back(ne);
                    st[t] = MFlight;
                    m_ptr = (t + 1) % N;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int t, input logic [7:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [2:0] tid);
        for (int i = 0; i < N; i++) begin
            if (i == t) begin
                req_op[i]  = op;
                req_a[i]   = a;
                req_b[i]   = b;
                req_tid[i] = tid;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int t = 0; t < N; t++) st[t] = MIdle;
        m_ptr     = 0;
        rst       = 1'b1;
        req_valid = '1;
        flush     = '0;
        res_ready = '0;
        set_req(0, OpMul, 64'd3, 64'd5, 3'd1);
        set_req(1, OpMul, 64'd3, 64'd5, 3'd2);
        repeat (3) cyc();

        // Both threads hammer MUL 3*5; grants alternate
        rst       = 1'b0;
        res_ready = '1;
        repeat (8) cyc();
        req_valid = '0;
        repeat (3) cyc();

        // Thread 0 MULH -2*3 held while consumer stalls
        set_req(0, OpMulh, -64'sd2, 64'd3, 3'd5);
        req_valid = 2'b01;
        res_ready = '0;
        repeat (7) cyc();
        req_valid = '0;
        res_ready = 2'b01;
        cyc();
        res_ready = '1;
        repeat (2) cyc();

        // Flush thread 1 the cycle after its grant, then re-request
        set_req(1, OpMul, 64'd7, 64'd6, 3'd2);
        req_valid = 2'b10;
        cyc();
        req_valid = '0;
        flush     = 2'b10;
        cyc();
        flush = '0;
        repeat (2) cyc();
        req_valid = 2'b10;
        cyc();
        req_valid = '0;
        repeat (3) cyc();

        // Flush thread 0 alongside both requests
        set_req(0, OpClmul, 64'hF0F0, 64'h1234, 3'd3);
        req_valid = 2'b11;
        flush     = 2'b01;
        cyc();
        flush = '0;
        cyc();
        req_valid = '0;
        repeat (3) cyc();

        // Back-to-back on thread 0 with result handshake
        set_req(0, OpMulw, 64'h0000_0001_8000_0001, 64'd3, 3'd6);
        req_valid = 2'b01;
        res_ready = 2'b01;
        repeat (6) cyc();
        req_valid = '0;
        res_ready = '1;
        repeat (3) cyc();

        repeat (3000) begin
            for (int t = 0; t < N; t++) begin
                req_valid[t] = ($urandom_range(0, 3) != 0);
                flush[t]     = ($urandom_range(0, 15) == 0);
                res_ready[t] = ($urandom_range(0, 3) != 0);
                set_req(t, 8'($urandom_range(0, 7)), {$urandom(), $urandom()},
                        {$urandom(), $urandom()}, 3'($urandom_range(0, 7)));
            end
            cyc();
        end

        req_valid = '0;
        flush     = '0;
        res_ready = '1;
        repeat (5) cyc();
        for (int t = 0; t < N; t++) begin
            chk($sformatf("drained_t%0d", t), 64'(expq[t].size()), 64'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
